data_io_fifo: RTL

- Next-generation MiST io-controller download block for the TRS-80 core.
- Receives the UIO file-transfer SPI protocol and writes the file into external RAM/SDRAM starting at a configurable address.
- Differences from the current download path:
  - fully synchronous to one system clock; SPI pins are oversampled, with no SPI-clock-domain logic;
  - parametrised RAM data width;
  - FIFO buffering with a wr/ack handshake, so slow or arbitrated memory can stall the writer;
  - overflow reporting.

---
 rtl/data_io_pkg.sv | 28 ++
 rtl/data_io_spi_rx.sv | 64 ++++++
 rtl/data_io_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/data_io_pkg.sv
// Shared constants, download-state type and CRC helper for the data_io_fifo download block.
// The optional CRC output of data_io_fifo is enabled with the DATA_IO_CRC_EN macro.
package data_io_pkg;

   localparam logic [7:0]  UIO_FILE_TX     = 8'h53;
   localparam logic [7:0]  UIO_FILE_TX_DAT = 8'h54;
   localparam logic [7:0]  UIO_FILE_INDEX  = 8'h55;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      DL_IDLE   = 2'd0,
      DL_ACTIVE = 2'd1,
      DL_DRAIN  = 2'd2
   } dl_state_e;

   // CRC-16-CCITT, MSB first, one byte per call.
   function automatic logic [15:0] crc16_byte(input logic [15:0] i_crc, input logic [7:0] i_byte);
      logic [15:0] w_c;
      w_c = i_crc ^ {i_byte, 8'h00};
      for (int i = 0; i < 8; i++) begin
         w_c = w_c[15] ? ((w_c << 1) ^ CRC_POLY) : (w_c << 1);
      end
      return w_c;
   endfunction

endpackage

// File: rtl/data_io_spi_rx.sv
// Oversampling UIO SPI receiver: synchronises sck/ss/sdi into clk, splits the
// stream into a command byte followed by any number of data bytes.
module data_io_spi_rx
   import data_io_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_sck,
   input  logic       i_ss,
   input  logic       i_sdi,
   output logic [7:0] o_cmd,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_data_phase
);

   logic [2:0] r_sck_sync;
   logic [1:0] r_ss_sync;
   logic [1:0] r_sdi_sync;
   logic [3:0] r_cnt;
   logic [6:0] r_sr;

   logic       w_sck_rise;
   logic [7:0] w_shift;

   assign w_sck_rise   = r_sck_sync[1] & ~r_sck_sync[2];
   assign w_shift      = {r_sr, r_sdi_sync[1]};
   assign o_data_phase = r_cnt[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sck_sync   <= '0;
         r_ss_sync    <= '0;
         r_sdi_sync   <= '0;
         r_cnt        <= '0;
         r_sr         <= '0;
         o_cmd        <= '0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
      end else begin
         r_sck_sync   <= {r_sck_sync[1:0], i_sck};
         r_ss_sync    <= {r_ss_sync[0], i_ss};
         r_sdi_sync   <= {r_sdi_sync[0], i_sdi};
         o_byte_valid <= 1'b0;
         if (r_ss_sync[1]) begin
            r_cnt <= '0;
         end else if (w_sck_rise) begin
            r_sr <= w_shift[6:0];
            // Counter runs 0-7 for the command, then loops 8-15 per data byte.
            if (r_cnt == 4'd7) begin
               o_cmd <= w_shift;
               r_cnt <= 4'd8;
            end else if (r_cnt == 4'd15) begin
               o_byte       <= w_shift;
               o_byte_valid <= 1'b1;
               r_cnt        <= 4'd8;
            end else begin
               r_cnt <= r_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/data_io_fifo.sv
// MiST/TRS-80 file download block: UIO SPI in, buffered wr/ack RAM writes out.
// Define DATA_IO_CRC_EN to add the crc output (CRC-16-CCITT over file data).
module data_io_fifo
   import data_io_pkg::*;
#(
   parameter logic [24:0] START_ADDR = 25'h4200,
   parameter int          ADDR_W     = 25,
   parameter int          DATA_W     = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter int          INDEX_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              ss,
   input  logic              sdi,
   output logic              downloading,
   output logic [INDEX_W-1:0] index,
   output logic [ADDR_W-1:0] size,
   output logic              overflow,
   output logic              wr,
   input  logic              ack,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output dl_state_e         dbg_state
`ifdef DATA_IO_CRC_EN
   ,
   output logic [15:0]       crc
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]        w_cmd;
   logic [7:0]        w_byte;
   logic              w_byte_valid;
   logic              w_data_phase;
   logic              w_rx_byte;
   logic              w_start;
   logic              w_eof;
   logic              w_dat_byte;
   logic              w_index;
   logic              w_push;
   logic              w_push_ok;
   logic              w_pop;
   logic              w_full;
   logic [DATA_W-1:0] w_push_data;
   dl_state_e         w_state_nxt;

   dl_state_e         r_state;
   logic [ADDR_W-1:0] r_size;
   logic [INDEX_W-1:0] r_index;
   logic              r_overflow;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];

   data_io_spi_rx u_spi_rx (
      .clk          (clk),
      .reset        (reset),
      .i_sck        (sck),
      .i_ss         (ss),
      .i_sdi        (sdi),
      .o_cmd        (w_cmd),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_data_phase (w_data_phase)
   );

   assign w_rx_byte  = w_byte_valid && w_data_phase;
   assign w_start    = w_rx_byte && (w_cmd == UIO_FILE_TX) && w_byte[0];
   assign w_eof      = w_rx_byte && (w_cmd == UIO_FILE_TX) && !w_byte[0] && downloading;
   assign w_dat_byte = w_rx_byte && (w_cmd == UIO_FILE_TX_DAT) && downloading;
   assign w_index    = w_rx_byte && (w_cmd == UIO_FILE_INDEX);

   generate
      if (DATA_W == 16) begin : g_pack16
         logic [7:0] r_lo;
         logic       r_half;
         always_ff @(posedge clk) begin
            if (reset || w_start) begin
               r_lo   <= '0;
               r_half <= 1'b0;
            end else if (w_dat_byte) begin
               if (!r_half) r_lo <= w_byte;
               r_half <= !r_half;
            end else if (w_eof) begin
               r_half <= 1'b0;
            end
         end
         // A trailing odd byte goes out with a zero high byte at end of file.
         assign w_push      = (w_dat_byte || w_eof) && r_half;
         assign w_push_data = w_dat_byte ? {w_byte, r_lo} : {8'h00, r_lo};
      end else begin : g_pack8
         assign w_push      = w_dat_byte;
         assign w_push_data = w_byte;
      end
   endgenerate

   assign w_pop     = r_wr && ack;
   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push_ok = w_push && (!w_full || w_pop);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DL_IDLE:   if (w_start) w_state_nxt = DL_ACTIVE;
         DL_ACTIVE: if (!w_start && w_eof) w_state_nxt = DL_DRAIN;
         DL_DRAIN: begin
            if (w_start)
               w_state_nxt = DL_ACTIVE;
            else if (r_count == '0 && !r_wr && !w_push)
               w_state_nxt = DL_IDLE;
         end
         default:   w_state_nxt = DL_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= DL_IDLE;
         r_size     <= '0;
         r_index    <= '0;
         r_overflow <= 1'b0;
         r_wr_addr  <= START_ADDR[ADDR_W-1:0];
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_wr       <= 1'b0;
         r_addr     <= START_ADDR[ADDR_W-1:0];
         r_data     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_size     <= '0;
            r_overflow <= 1'b0;
            r_wr_addr  <= START_ADDR[ADDR_W-1:0];
         end else begin
            if (w_dat_byte) r_size <= r_size + ADDR_W'(1);
            // The address tracks file offset even for dropped words.
            if (w_push) r_wr_addr <= r_wr_addr + ADDR_W'(DATA_W / 8);
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
         end
         if (w_index) r_index <= w_byte[INDEX_W-1:0];
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (!r_wr && r_count != '0) begin
            r_wr   <= 1'b1;
            r_addr <= r_mem_addr[r_rd_ptr];
            r_data <= r_mem_data[r_rd_ptr];
         end else if (w_pop) begin
            r_wr <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem_addr[r_wr_ptr] <= r_wr_addr;
         r_mem_data[r_wr_ptr] <= w_push_data;
      end
   end

`ifdef DATA_IO_CRC_EN
   logic        r_crc_pend;
   logic [7:0]  r_crc_byte;
   logic [15:0] r_crc;

   always_ff @(posedge clk) begin
      if (reset || w_start) begin
         r_crc_pend <= 1'b0;
         r_crc_byte <= '0;
         r_crc      <= CRC_INIT;
      end else begin
         r_crc_pend <= w_dat_byte;
         if (w_dat_byte) r_crc_byte <= w_byte;
         if (r_crc_pend) r_crc <= crc16_byte(r_crc, r_crc_byte);
      end
   end

   assign crc = r_crc;
`endif

   assign downloading = (r_state != DL_IDLE);
   assign index       = r_index;
   assign size        = r_size;
   assign overflow    = r_overflow;
   assign wr          = r_wr;
   assign addr        = r_addr;
   assign data        = r_data;
   assign dbg_state   = r_state;

endmodule
